// File: rtl/serial_chunker.sv
// Collects received bytes into a shifting window and hands PAT_W-bit chunks to the
// pattern matcher over a valid/ready handshake, in either BLOCK or SLIDE mode.
module serial_chunker #(
  parameter int BYTE_W      = 8,
  parameter int CHUNK_BYTES = 4,
  parameter int PAT_W       = 30,
  parameter int STRIDE      = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              mode_i,
  input  logic              flush_i,
  output logic [PAT_W-1:0]  out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  chunk_count_o,
  output logic              overflow_o
);

  localparam int WIN_W  = CHUNK_BYTES * BYTE_W;
  localparam int FILL_W = $clog2(CHUNK_BYTES + 1);
  localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE + 1) : 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(CHUNK_BYTES);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(CHUNK_BYTES - 1);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRIDE - 1);

  if (STRIDE < 1 || STRIDE > CHUNK_BYTES) begin : g_bad_stride
    $error("serial_chunker: STRIDE must lie in 1..CHUNK_BYTES");
  end
  if (PAT_W > WIN_W) begin : g_bad_pat_w
    $error("serial_chunker: PAT_W must not exceed CHUNK_BYTES*BYTE_W");
  end

  typedef enum logic {
    MODE_BLOCK = 1'b0,
    MODE_SLIDE = 1'b1
  } mode_e;

  logic [WIN_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [STR_W-1:0]  stride_q, stride_d;
  mode_e             mode_q, mode_d;
  logic [PAT_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              chunk_done;
  logic [WIN_W-1:0]  win_shift;

  assign accept = in_valid_i && !flush_i;

  // The oldest byte falls out of the window on every shift and never reaches an output.
  if (CHUNK_BYTES > 1) begin : g_shift
    logic unused_oldest;
    assign unused_oldest = ^win_q[WIN_W-1 -: BYTE_W];
    assign win_shift     = {win_q[WIN_W-BYTE_W-1:0], in_data_i};
  end else begin : g_single
    logic unused_oldest;
    assign unused_oldest = ^win_q;
    assign win_shift     = in_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q    <= '0;
      fill_q   <= '0;
      stride_q <= '0;
      mode_q   <= MODE_BLOCK;
      data_q   <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      win_q    <= win_d;
      fill_q   <= fill_d;
      stride_q <= stride_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    win_d      = win_q;
    fill_d     = fill_q;
    stride_d   = stride_q;
    mode_d     = mode_q;
    data_d     = data_q;
    valid_d    = valid_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    chunk_done = 1'b0;

    // Mode only switches between windows so a chunk is never assembled under two rules.
    if (fill_q == '0 && !accept) begin
      mode_d = mode_e'(mode_i);
    end

    if (flush_i) begin
      win_d    = '0;
      fill_d   = '0;
      stride_d = '0;
      data_d   = '0;
      valid_d  = 1'b0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (accept) begin
        win_d = win_shift;
        if (mode_q == MODE_BLOCK) begin
          if (fill_q == FILL_LAST) begin
            fill_d     = '0;
            chunk_done = 1'b1;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end else if (fill_q != FILL_FULL) begin
          fill_d     = fill_q + 1'b1;
          chunk_done = (fill_q == FILL_LAST);
        end else if (stride_q == STR_LAST) begin
          stride_d   = '0;
          chunk_done = 1'b1;
        end else begin
          stride_d = stride_q + 1'b1;
        end
      end

      // A held chunk that is not being taken this cycle wins over a freshly completed one.
      if (chunk_done) begin
        if (!valid_q || out_ready_i) begin
          data_d  = win_shift[PAT_W-1:0];
          valid_d = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (valid_q && out_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  assign out_data_o    = data_q;
  assign out_valid_o   = valid_q;
  assign chunk_count_o = count_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_serial_chunker.sv
// Directed bench for serial_chunker: stimulus queues expected chunks, a monitor
// checks each one as it is handed over on out_valid && out_ready.
module tb_serial_chunker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        mode_i;
  logic        flush_i;
  logic [29:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] chunk_count_o;
  logic        overflow_o;

  typedef struct packed {
    logic [29:0] data;
    logic [31:0] count;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   checkCount = 0;
  int   failCount  = 0;

  serial_chunker #(
    .BYTE_W(8), .CHUNK_BYTES(4), .PAT_W(30), .STRIDE(1), .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data_i(in_data_i),
    .in_valid_i(in_valid_i),
    .mode_i(mode_i),
    .flush_i(flush_i),
    .out_data_o(out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .chunk_count_o(chunk_count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectChunk(input logic [29:0] d, input logic [31:0] c);
    sbQ.push_back({d, c});
  endtask

  // Presents one byte for exactly one clock; back-to-back calls give a byte every cycle.
  task automatic applyStimulus(input logic [7:0] b);
    in_valid_i = 1'b1;
    in_data_i  = b;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic doFlush(input logic m);
    mode_i  = m;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    idle(1);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid_o && out_ready_i) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_chunk", 64'd1, 64'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("chunk_data", 64'(out_data_o), 64'(monE.data));
        checkOutput("chunk_count_at_xfer", 64'(chunk_count_o), 64'(monE.count));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    in_data_i   = '0;
    in_valid_i  = 1'b0;
    mode_i      = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset_data", 64'(out_data_o), 64'd0);
    checkOutput("reset_count", 64'(chunk_count_o), 64'd0);
    checkOutput("reset_overflow", 64'(overflow_o), 64'd0);

    // BLOCK, top two bits of the oldest byte dropped
    expectChunk(30'h31223344, 32'd1);
    applyStimulus(8'hF1); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    checkOutput("t1_valid", 64'(out_valid_o), 64'd1);
    checkOutput("t1_data", 64'(out_data_o), 64'h31223344);
    checkOutput("t1_count", 64'(chunk_count_o), 64'd1);
    idle(1);
    checkOutput("t1_valid_drop", 64'(out_valid_o), 64'd0);

    // SLIDE, stride 1: valid stays high across accept+load
    doFlush(1'b1);
    expectChunk(30'h01020304, 32'd1);
    expectChunk(30'h02030405, 32'd2);
    expectChunk(30'h03040506, 32'd3);
    for (int i = 1; i <= 6; i++) applyStimulus(8'(i));
    checkOutput("t2_valid", 64'(out_valid_o), 64'd1);
    checkOutput("t2_count", 64'(chunk_count_o), 64'd3);
    idle(1);
    checkOutput("t2_valid_drop", 64'(out_valid_o), 64'd0);
    checkOutput("t2_data_retained", 64'(out_data_o), 64'h03040506);

    // BLOCK with consumer stalled: second chunk dropped
    doFlush(1'b0);
    out_ready_i = 1'b0;
    expectChunk(30'h11223344, 32'd1);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i * 'h11));
    checkOutput("t3_valid_held", 64'(out_valid_o), 64'd1);
    checkOutput("t3_data_held", 64'(out_data_o), 64'h11223344);
    checkOutput("t3_overflow", 64'(overflow_o), 64'd1);
    checkOutput("t3_count", 64'(chunk_count_o), 64'd1);
    out_ready_i = 1'b1;
    idle(1);
    checkOutput("t3_valid_drop", 64'(out_valid_o), 64'd0);
    checkOutput("t3_overflow_sticky", 64'(overflow_o), 64'd1);

    // BLOCK, ready=1, eight bytes back to back
    doFlush(1'b0);
    expectChunk(30'h01020304, 32'd1);
    expectChunk(30'h05060708, 32'd2);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    checkOutput("t4_valid", 64'(out_valid_o), 64'd1);
    checkOutput("t4_count", 64'(chunk_count_o), 64'd2);
    checkOutput("t4_overflow", 64'(overflow_o), 64'd0);
    idle(2);

    // Partial window and the byte coincident with flush are both lost
    doFlush(1'b0);
    applyStimulus(8'h55); applyStimulus(8'h66);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'h77;
    @(posedge clk); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    expectChunk(30'h2ABBCCDD, 32'd1);
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD);
    checkOutput("t5_count", 64'(chunk_count_o), 64'd1);
    idle(2);

    // Async reset mid-window, then again while a chunk is held
    applyStimulus(8'h01); applyStimulus(8'h02);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst1_data", 64'(out_data_o), 64'd0);
    checkOutput("t6_rst1_count", 64'(chunk_count_o), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    out_ready_i = 1'b0;
    applyStimulus(8'h0A); applyStimulus(8'h0B); applyStimulus(8'h0C);
    checkOutput("t6_partial_no_valid", 64'(out_valid_o), 64'd0);
    applyStimulus(8'h0D);
    checkOutput("t6_valid", 64'(out_valid_o), 64'd1);
    checkOutput("t6_data", 64'(out_data_o), 64'h0A0B0C0D);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst2_valid", 64'(out_valid_o), 64'd0);
    checkOutput("t6_rst2_data", 64'(out_data_o), 64'd0);
    checkOutput("t6_rst2_count", 64'(chunk_count_o), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    out_ready_i = 1'b1;
    expectChunk(30'h21324354, 32'd1);
    applyStimulus(8'h21); applyStimulus(8'h32); applyStimulus(8'h43); applyStimulus(8'h54);
    idle(3);

    checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
